md_unit: RTL and testbench

Multiply/divide unit of the Execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage controller and runs multi-cycle operations against private HI/LO registers. It drives MFHI/MFLO data into the E/M pipeline register, which becomes md_M_i in the Memory stage. It also exposes busy so the hazard unit can stall D-stage md instructions. Starts are cancelled by the Memory stage's exception request so that flushed instructions never modify HI/LO.

---
 rtl/md_pkg.sv | 19 +
 rtl/md_unit.sv | 138 +++++++++++++
 tb/tb_md_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the Execute-stage multiply/divide unit.
//   md_op_e        - operation encodings driven by the E-stage controller
//   MD_*_CYCLES    - default busy latencies for multiply and divide
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage : md_pkg

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   md_op   - operation (md_pkg::md_op_e encoding; 7 behaves as NONE)
//   rs, rt  - forwarded operands
//   req     - Memory-stage exception request; cancels an E-stage start
//   rd_hi   - md_out select: 1 = HI, 0 = LO
//   busy    - high while a multiply/divide is in flight
//   hi, lo  - registered HI/LO
//   md_out  - combinational MFHI/MFLO data (no bypass of same-cycle writes)
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        req,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Datapath: full-width product and sign-magnitude division.
    logic        mul_sext;
    logic [63:0] mul_a, mul_b, product;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    always_comb begin
        mul_sext = (md_op == MD_MULT);
        mul_a    = {{32{mul_sext & rs[31]}}, rs};
        mul_b    = {{32{mul_sext & rt[31]}}, rt};
        product  = mul_a * mul_b;

        // Dividing magnitudes keeps 0x80000000 / -1 well defined: the
        // magnitude quotient is 0x80000000 and the sign is positive.
        div_signed = (md_op == MD_DIV);
        a_neg      = div_signed & rs[31];
        b_neg      = div_signed & rt[31];
        a_mag      = a_neg ? (~rs + 32'd1) : rs;
        b_mag      = b_neg ? (~rt + 32'd1) : rt;
        b_safe     = (rt == '0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (!req) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            shadow_d = product;
                            dz_d     = 1'b0;
                            cnt_d    = 4'(MULT_CYCLES);
                            state_d  = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            shadow_d = {rem, quot};
                            dz_d     = (rt == '0);
                            cnt_d    = 4'(DIV_CYCLES);
                            state_d  = ST_RUN;
                        end
                        MD_MTHI: hi_d = rs;
                        MD_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // req is deliberately ignored here: the in-flight op belongs
                // to an older instruction that is not being flushed.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (!dz_q) begin
                        hi_d = shadow_q[63:32];
                        lo_d = shadow_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = rd_hi ? hi_q : lo_q;

endmodule : md_unit

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] rs, rt;
    logic        req, rd_hi;
    logic        busy;
    logic [31:0] hi, lo, md_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .rs(rs), .rt(rt),
        .req(req), .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo),
        .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Present an op for exactly one rising edge; returns at the following negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        @(negedge clk);
        md_op = op; rs = a; rt = b; req = r;
        @(negedge clk);
        md_op = 3'(MD_NONE); req = 1'b0;
    endtask

    // Count negedge samples with busy high, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; md_op = '0; rs = '0; rt = '0; req = 1'b0; rd_hi = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int n;
        exp_t e;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA});
        issue(3'(MD_MULT), 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== MC) begin bad++; $display("FAIL mult_latency: got %0d expected %0d", n, MC); end
        total++;
        if (hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL mult_result: hi=%h lo=%h expected %h %h", hi, lo, e.hi, e.lo);
        end
        sb.push_back('{32'h00000002, 32'hFFFFFFFA});
        issue(3'(MD_MULTU), 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (hi !== e.hi || lo !== e.lo || n !== MC) begin
            bad++; $display("FAIL multu_result: hi=%h lo=%h n=%0d expected %h %h %0d", hi, lo, n, e.hi, e.lo, MC);
        end
    endtask

    task automatic test_random;
        int n;
        exp_t e;
        logic [31:0] a, b;
        longint p;
        longint unsigned pu;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            case (i % 3)
                0: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    sb.push_back('{p[63:32], p[31:0]});
                    issue(3'(MD_MULT), a, b, 1'b0);
                end
                1: begin
                    pu = {32'd0, a} * {32'd0, b};
                    sb.push_back('{pu[63:32], pu[31:0]});
                    issue(3'(MD_MULTU), a, b, 1'b0);
                end
                default: begin
                    b = $urandom_range(65535, 1);
                    sb.push_back('{a % b, a / b});
                    issue(3'(MD_DIVU), a, b, 1'b0);
                end
            endcase
            wait_idle(n);
            e = sb.pop_front();
            total++;
            if (hi !== e.hi || lo !== e.lo) begin
                bad++; $display("FAIL random_%0d: hi=%h lo=%h expected %h %h (a=%h b=%h)", i, hi, lo, e.hi, e.lo, a, b);
            end
        end
    endtask

    task automatic test_div;
        int n;
        exp_t e;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(3'(MD_DIV), 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== DC) begin bad++; $display("FAIL div_latency: got %0d expected %0d", n, DC); end
        total++;
        if (hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL div_result: hi=%h lo=%h expected %h %h", hi, lo, e.hi, e.lo);
        end
        // Divide by zero keeps whatever hi/lo held before.
        issue(3'(MD_MTHI), 32'h11112222, '0, 1'b0);
        issue(3'(MD_MTLO), 32'h33334444, '0, 1'b0);
        sb.push_back('{32'h11112222, 32'h33334444});
        issue(3'(MD_DIVU), 32'd7, 32'd0, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== DC || hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL div_by_zero: n=%0d hi=%h lo=%h expected %0d %h %h", n, hi, lo, DC, e.hi, e.lo);
        end
        sb.push_back('{32'h00000000, 32'h80000000});
        issue(3'(MD_DIV), 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL div_overflow: hi=%h lo=%h expected %h %h", hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_cancel;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        issue(3'(MD_MULT), 32'd9, 32'd9, 1'b1);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cancel_mult_busy: busy=%b expected 0", busy); end
        repeat (MC) @(negedge clk);
        total++;
        if (hi !== h0 || lo !== l0) begin
            bad++; $display("FAIL cancel_mult_hilo: hi=%h lo=%h expected %h %h", hi, lo, h0, l0);
        end
        issue(3'(MD_MTLO), 32'h00001234, '0, 1'b1);
        total++;
        if (lo !== l0) begin bad++; $display("FAIL cancel_mtlo: lo=%h expected %h", lo, l0); end
    endtask

    task automatic test_req_mid;
        int n;
        exp_t e;
        sb.push_back('{32'd1, 32'd33});
        issue(3'(MD_DIVU), 32'd100, 32'd3, 1'b0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0; md_op = 3'(MD_MULT); rs = 32'd5; rt = 32'd5;
        @(negedge clk);
        md_op = 3'(MD_NONE);
        wait_idle(n);
        n = n + 2;
        e = sb.pop_front();
        total++;
        if (n !== DC) begin bad++; $display("FAIL req_mid_latency: got %0d expected %0d", n, DC); end
        total++;
        if (hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL req_mid_result: hi=%h lo=%h expected %h %h", hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        exp_t e;
        logic [31:0] old_hi;
        old_hi = hi;
        rd_hi = 1'b1;
        @(negedge clk);
        md_op = 3'(MD_MTHI); rs = 32'hAAAA55AA;
        #1;
        total++;
        if (md_out !== old_hi) begin bad++; $display("FAIL mthi_no_bypass: md_out=%h expected %h", md_out, old_hi); end
        @(negedge clk);
        md_op = 3'(MD_NONE);
        total++;
        if (md_out !== 32'hAAAA55AA) begin bad++; $display("FAIL mfhi: md_out=%h expected aaaa55aa", md_out); end
        rd_hi = 1'b0;

        sb.push_back('{32'd0, 32'd12});
        issue(3'(MD_MULTU), 32'd3, 32'd4, 1'b0);
        repeat (MC - 1) @(negedge clk);
        // Held across the edge where busy falls (ignored) and the next (accepted).
        md_op = 3'(MD_MULTU); rs = 32'd6; rt = 32'd7;
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (busy !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL b2b_first: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, e.hi, e.lo);
        end
        sb.push_back('{32'd0, 32'd42});
        @(negedge clk);
        md_op = 3'(MD_NONE);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== MC || hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL b2b_second: n=%0d hi=%h lo=%h expected %0d %h %h", n, hi, lo, MC, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        exp_t e;
        issue(3'(MD_MULTU), 32'd10, 32'd10, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFF1});
        issue(3'(MD_MULT), 32'hFFFFFFFD, 32'd5, 1'b0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== MC || hi !== e.hi || lo !== e.lo) begin
            bad++; $display("FAIL after_reset: n=%0d hi=%h lo=%h expected %0d %h %h", n, hi, lo, MC, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_random;
        test_cancel;
        test_req_mid;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_md_unit
